temp_alarm_monitor: RTL
=======================

// Module: temp_alarm_monitor
// PURPOSE
// - Watches the temperature sample stream from the sensor front-end and decides when the board is over-temperature.
// - Uses a high/low hysteresis pair plus N-consecutive-sample confirmation so noise cannot retrigger.
// - Emits a one-cycle alarm_pulse that drives the LED flasher's control input, and a level alarm_active for the display path.
// PARAMETERS
// - DATA_W   16  sample/threshold width; two's complement, 1/128 degC per LSB (sensor 16-bit mode)
// - CONFIRM  4   consecutive qualifying samples needed to enter or leave alarm; legal range 1..255
// PORTS
// - clk           in   1        system clock
// - reset         in   1        asynchronous, active-high
// - temp_valid    in   1        one-cycle strobe; temp_data is meaningful only when high
// - temp_data     in   DATA_W   signed temperature sample
// - thr_high      in   DATA_W   signed alarm-entry threshold; sample qualifies if temp_data >= thr_high
// - thr_low       in   DATA_W   signed alarm-exit threshold; sample qualifies if temp_data < thr_low
// - alarm_pulse   out  1        one-cycle pulse on alarm entry (to flasher control)
// - alarm_active  out  1        level: block is in alarm
// - cfg_err       out  1        registered: thr_low > thr_high
// BEHAVIOUR
// - Clock and reset: reset is asynchronous, active-high; clock is clk.
// - Reset: state=NORMAL, cnt=0; alarm_pulse=0, alarm_active=0, cfg_err=0.
// - All outputs are registered. All comparisons are signed, full DATA_W; no saturation.
// - cnt width: $clog2(CONFIRM+1) bits. It never wraps; it is cleared on every state change.
// - State machine: NORMAL, PEND_HI, ALARM, PEND_LO. It advances only on cycles with temp_valid=1.
//   NORMAL : qualifying high sample -> cnt=1. If CONFIRM==1, go to ALARM; else go to PEND_HI.
//   PEND_HI: high sample -> cnt+1. When cnt reaches CONFIRM, go to ALARM.
//            Non-high sample -> go to NORMAL, cnt=0 (streak broken).
//   ALARM  : sample < thr_low -> cnt=1. If CONFIRM==1, go to NORMAL; else go to PEND_LO.
//            Any other sample -> stay in ALARM.
//   PEND_LO: low sample -> cnt+1. When cnt reaches CONFIRM, go to NORMAL.
//            Non-low sample -> go to ALARM, cnt=0.
// - alarm_pulse is 1 exactly in the cycle after the edge that sampled the CONFIRMth high sample. Latency = 1 clk.
// - alarm_active is 1 while state is ALARM or PEND_LO. It rises together with alarm_pulse.
//   It falls 1 clk after the edge that sampled the CONFIRMth low sample.
// - Samples between thr_low and thr_high are hysteresis-band samples: they break any pending streak.
// - thr_low == thr_high is legal; the band is empty.
// - cfg_err is set when thr_low > thr_high, evaluated every cycle.
//   While cfg_err=1: state is forced to NORMAL, cnt=0, alarm_pulse=0, alarm_active=0.
// - Threshold inputs are quasi-static. Any change takes effect on the next temp_valid; no re-qualification of past samples.
// - temp_valid on back-to-back cycles is legal; each strobe counts once.
// - Reset asserted mid-streak or mid-alarm: immediate return to reset values.
//   No pulse is produced on reset release.
// CONFIGURATION
// - Macro ALARM_STICKY_EN.
// - Defined: an extra input port alarm_clr (1 bit, one-cycle strobe) is added.
//   alarm_active stays 1 after the FSM returns to NORMAL, until alarm_clr=1 is sampled while state==NORMAL.
//   alarm_clr while in ALARM/PEND_LO is ignored.
//   A new alarm entry while sticky still pulses alarm_pulse again.
//   Reset and cfg_err clear the sticky flag.
// - Undefined: no alarm_clr port; alarm_active strictly follows the FSM as above.
// TESTING
// - CONFIRM=4, thr_high=0x0F00 (30C), thr_low=0x0E00 (28C).
//   4 valid samples of 0x0F00 -> alarm_pulse high for exactly 1 clk after the 4th, alarm_active=1.
// - 3 samples of 0x0F80, then 1 of 0x0E80 (band), then 3 of 0x0F80 -> no alarm_pulse, alarm_active stays 0.
// - In alarm: 4 samples of 0xFB00 (-10C) with idle gaps of 0..5 clk between strobes
//   -> alarm_active falls 1 clk after the 4th; no alarm_pulse.
// - Set thr_low=0x1000, thr_high=0x0F00 while in alarm -> cfg_err=1 next clk, alarm_active=0.
//   Restoring the thresholds -> cfg_err=0; then 4 samples of 0x0F00 are needed to re-alarm.
// - Assert reset after the 2nd of 4 high samples; release; send 4 more
//   -> all outputs 0 during reset; exactly one alarm_pulse, after the 4th post-reset sample.
// - With ALARM_STICKY_EN: alarm, then 4 low samples -> alarm_active stays 1.
//   alarm_clr pulse -> alarm_active=0 next clk.

Source files
------------

// File: rtl/temp_alarm_monitor.sv
// Over-temperature detector: hysteresis thresholds plus CONFIRM-sample qualification on entry and exit.
// Optional ALARM_STICKY_EN macro latches alarm_active until alarm_clr is seen in NORMAL.
module temp_alarm_monitor #(
  parameter int DATA_W  = 16,
  parameter int CONFIRM = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              temp_valid,
  input  logic [DATA_W-1:0] temp_data,
  input  logic [DATA_W-1:0] thr_high,
  input  logic [DATA_W-1:0] thr_low,
`ifdef ALARM_STICKY_EN
  input  logic              alarm_clr,
`endif
  output logic              alarm_pulse,
  output logic              alarm_active,
  output logic              cfg_err
);

  localparam int CNT_W = (CONFIRM < 2) ? 1 : $clog2(CONFIRM + 1);
  localparam logic [CNT_W-1:0] CONFIRM_C = CNT_W'(CONFIRM);

  typedef enum logic [1:0] {NORMAL, PEND_HI, ALARM, PEND_LO} state_t;

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next, cnt_inc;
  logic             pulse_reg, pulse_next;
  logic             active_reg, active_next;
  logic             cfg_err_reg;
  logic             is_high, is_low, cfg_bad, in_alarm_next;

  assign is_high = $signed(temp_data) >= $signed(thr_high);
  assign is_low  = $signed(temp_data) <  $signed(thr_low);
  assign cfg_bad = $signed(thr_low)   >  $signed(thr_high);
  assign cnt_inc = cnt_reg + 1'b1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg   <= NORMAL;
      cnt_reg     <= '0;
      pulse_reg   <= 1'b0;
      active_reg  <= 1'b0;
      cfg_err_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      pulse_reg   <= pulse_next;
      active_reg  <= active_next;
      cfg_err_reg <= cfg_bad;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    if (cfg_bad) begin
      state_next = NORMAL;
      cnt_next   = '0;
    end else if (temp_valid) begin
      case (state_reg)
        NORMAL: begin
          if (is_high) begin
            if (CONFIRM == 1) begin
              state_next = ALARM;
              cnt_next   = '0;
            end else begin
              state_next = PEND_HI;
              cnt_next   = CNT_W'(1);
            end
          end
        end
        PEND_HI: begin
          if (!is_high) begin
            state_next = NORMAL;
            cnt_next   = '0;
          end else if (cnt_inc == CONFIRM_C) begin
            state_next = ALARM;
            cnt_next   = '0;
          end else begin
            cnt_next = cnt_inc;
          end
        end
        ALARM: begin
          if (is_low) begin
            if (CONFIRM == 1) begin
              state_next = NORMAL;
              cnt_next   = '0;
            end else begin
              state_next = PEND_LO;
              cnt_next   = CNT_W'(1);
            end
          end
        end
        PEND_LO: begin
          if (!is_low) begin
            state_next = ALARM;
            cnt_next   = '0;
          end else if (cnt_inc == CONFIRM_C) begin
            state_next = NORMAL;
            cnt_next   = '0;
          end else begin
            cnt_next = cnt_inc;
          end
        end
        default: begin
          state_next = NORMAL;
          cnt_next   = '0;
        end
      endcase
    end
  end

  // Only a fresh entry pulses; falling back from PEND_LO to ALARM is not an entry.
  always_comb begin
    in_alarm_next = (state_next == ALARM) || (state_next == PEND_LO);
    pulse_next    = !cfg_bad && (state_next == ALARM) &&
                    ((state_reg == NORMAL) || (state_reg == PEND_HI));
  end

`ifdef ALARM_STICKY_EN
  // The level stays latched after recovery until acknowledged while NORMAL.
  always_comb begin
    active_next = active_reg;
    if (cfg_bad)
      active_next = 1'b0;
    else if (in_alarm_next)
      active_next = 1'b1;
    else if (alarm_clr && (state_reg == NORMAL))
      active_next = 1'b0;
  end
`else
  always_comb begin
    active_next = in_alarm_next;
  end
`endif

  assign alarm_pulse  = pulse_reg;
  assign alarm_active = active_reg;
  assign cfg_err      = cfg_err_reg;

endmodule
